ifetch_unit: RTL and testbench

- Instruction fetch / next-PC sequencer for the MIPS core.
- Holds the PC, runs a request/valid handshake with instruction memory, and presents op/functy to the control decoder.
- Consumes the decoder's pcbranch/pcjmp/pcreg redirect outputs to compute the next PC.
- Halts on syscall-exit and keeps instruction, branch and jump statistics counters.

---
 rtl/ifetch_unit_pkg.sv | 42 ++++
 rtl/ifetch_unit_if.sv | 28 ++
 rtl/ifetch_unit_npc_calc.sv | 40 ++++
 rtl/ifetch_unit.sv | 146 ++++++++++++++
 tb/tb_ifetch_unit.sv | 321 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ifetch_unit_pkg.sv
// Shared definitions for the instruction fetch / next-PC sequencer.
// Contents: FSM state encoding, the reset PC default, instruction field positions,
// the MIPS opcode/functy constants used by the core, and a branch offset helper.
package ifetch_unit_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StFetch = 2'd1,
    StExec  = 2'd2,
    StHalt  = 2'd3
  } state_e;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // Instruction field positions
  localparam int unsigned OP_MSB  = 31;
  localparam int unsigned OP_LSB  = 26;
  localparam int unsigned FN_MSB  = 5;
  localparam int unsigned FN_LSB  = 0;
  localparam int unsigned IMM_MSB = 15;
  localparam int unsigned IMM_LSB = 0;
  localparam int unsigned TGT_MSB = 25;
  localparam int unsigned TGT_LSB = 0;

  // Opcodes
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;

  // R-type function codes
  localparam logic [5:0] FN_JR      = 6'h08;
  localparam logic [5:0] FN_SYSCALL = 6'h0C;
  localparam logic [5:0] FN_ADD     = 6'h20;

  // Word offset of a branch: sign-extended imm16 shifted left by two.
  function automatic logic [31:0] branch_offset(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/ifetch_unit_if.sv
// Instruction memory request/valid bus.
// imem_req   : fetch request, held until imem_valid
// imem_addr  : fetch address, stable while imem_req is high
// imem_valid : response valid (one cycle)
// imem_rdata : fetched instruction word, qualified by imem_valid
// master: fetch unit side, slave: memory side.
interface ifetch_unit_if;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_valid;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_valid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_valid,
    output imem_rdata
  );

endinterface

// File: rtl/ifetch_unit_npc_calc.sv
// Combinational next-PC computation.
// Inputs : pc_i, instr_i (low 26 bits: target26 / imm16), reg_target_i, redirect flags.
// Outputs: pc_plus4_o, next_pc_o (priority pcreg > pcjmp > pcbranch > sequential),
//          misaligned_o (jr to a non word-aligned address).
module ifetch_unit_npc_calc
  import ifetch_unit_pkg::*;
(
  input  logic [31:0] pc_i,
  input  logic [25:0] instr_i,
  input  logic [31:0] reg_target_i,
  input  logic        pcbranch_i,
  input  logic        pcjmp_i,
  input  logic        pcreg_i,
  output logic [31:0] pc_plus4_o,
  output logic [31:0] next_pc_o,
  output logic        misaligned_o
);

  logic [31:0] jump_tgt;
  logic [31:0] branch_tgt;

  always_comb begin
    // 32-bit add wraps 32'hFFFF_FFFC to 0 naturally
    pc_plus4_o   = pc_i + 32'd4;
    jump_tgt     = {pc_plus4_o[31:28], instr_i[TGT_MSB:TGT_LSB], 2'b00};
    branch_tgt   = pc_plus4_o + branch_offset(instr_i[IMM_MSB:IMM_LSB]);
    misaligned_o = pcreg_i && (reg_target_i[1:0] != 2'b00);

    if (pcreg_i) begin
      next_pc_o = reg_target_i;
    end else if (pcjmp_i) begin
      next_pc_o = jump_tgt;
    end else if (pcbranch_i) begin
      next_pc_o = branch_tgt;
    end else begin
      next_pc_o = pc_plus4_o;
    end
  end

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch / next-PC sequencer.
// clk, rst       : clock, asynchronous active-high reset
// en             : run enable, gates the start of each new fetch
// imem           : instruction memory request/valid bus (master side)
// instr/op/functy: latched instruction and decoder fields
// instr_valid    : instruction executing this cycle (EXEC)
// pc, pc_plus4   : current instruction address and its link value
// pcbranch/pcjmp/pcreg/reg_target: decoder redirect inputs, sampled in EXEC
// halt_req       : syscall-exit, sampled in EXEC
// halted, fault  : sequencer stopped / stopped on misaligned jr
// instr_cnt, branch_cnt, jump_cnt: wrapping statistics counters
module ifetch_unit
  import ifetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter int unsigned CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  ifetch_unit_if.master        imem,
  output logic [31:0]          instr,
  output logic [5:0]           op,
  output logic [5:0]           functy,
  output logic                 instr_valid,
  output logic [31:0]          pc,
  output logic [31:0]          pc_plus4,
  input  logic                 pcbranch,
  input  logic                 pcjmp,
  input  logic                 pcreg,
  input  logic [31:0]          reg_target,
  input  logic                 halt_req,
  output logic                 halted,
  output logic                 fault,
  output logic [CNT_WIDTH-1:0] instr_cnt,
  output logic [CNT_WIDTH-1:0] branch_cnt,
  output logic [CNT_WIDTH-1:0] jump_cnt
);

  localparam logic [CNT_WIDTH-1:0] CntOne = 1;

  state_e               state_q;
  logic [31:0]          pc_q;
  logic [31:0]          instr_q;
  logic                 req_q;
  logic                 instr_valid_q;
  logic                 halted_q;
  logic                 fault_q;
  logic [CNT_WIDTH-1:0] instr_cnt_q;
  logic [CNT_WIDTH-1:0] branch_cnt_q;
  logic [CNT_WIDTH-1:0] jump_cnt_q;

  logic [31:0] next_pc;
  logic        misaligned;

  ifetch_unit_npc_calc u_npc_calc (
    .pc_i         (pc_q),
    .instr_i      (instr_q[TGT_MSB:0]),
    .reg_target_i (reg_target),
    .pcbranch_i   (pcbranch),
    .pcjmp_i      (pcjmp),
    .pcreg_i      (pcreg),
    .pc_plus4_o   (pc_plus4),
    .next_pc_o    (next_pc),
    .misaligned_o (misaligned)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StIdle;
      pc_q          <= RESET_PC;
      instr_q       <= 32'd0;
      req_q         <= 1'b0;
      instr_valid_q <= 1'b0;
      halted_q      <= 1'b0;
      fault_q       <= 1'b0;
      instr_cnt_q   <= '0;
      branch_cnt_q  <= '0;
      jump_cnt_q    <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (en) begin
            state_q <= StFetch;
            req_q   <= 1'b1;
          end
        end

        StFetch: begin
          // en is not looked at here: an issued request always completes and executes
          if (imem.imem_valid) begin
            instr_q       <= imem.imem_rdata;
            req_q         <= 1'b0;
            instr_valid_q <= 1'b1;
            state_q       <= StExec;
          end
        end

        StExec: begin
          instr_valid_q <= 1'b0;
          instr_cnt_q   <= instr_cnt_q + CntOne;
          if (halt_req) begin
            // syscall-exit overrides every redirect; pc keeps the syscall address
            state_q  <= StHalt;
            halted_q <= 1'b1;
          end else if (misaligned) begin
            state_q  <= StHalt;
            halted_q <= 1'b1;
            fault_q  <= 1'b1;
          end else begin
            pc_q <= next_pc;
            if (pcjmp || pcreg) begin
              jump_cnt_q <= jump_cnt_q + CntOne;
            end else if (pcbranch) begin
              branch_cnt_q <= branch_cnt_q + CntOne;
            end
            if (en) begin
              state_q <= StFetch;
              req_q   <= 1'b1;
            end else begin
              state_q <= StIdle;
            end
          end
        end

        StHalt: begin
          state_q <= StHalt;
        end
      endcase
    end
  end

  assign imem.imem_req  = req_q;
  assign imem.imem_addr = pc_q;
  assign instr          = instr_q;
  assign op             = instr_q[OP_MSB:OP_LSB];
  assign functy         = instr_q[FN_MSB:FN_LSB];
  assign instr_valid    = instr_valid_q;
  assign pc             = pc_q;
  assign halted         = halted_q;
  assign fault          = fault_q;
  assign instr_cnt      = instr_cnt_q;
  assign branch_cnt     = branch_cnt_q;
  assign jump_cnt       = jump_cnt_q;

endmodule

// File: tb/tb_ifetch_unit.sv
// Scoreboard bench for ifetch_unit: the driver plays instruction memory and decoder,
// pushes each expected executed instruction, and a monitor pops and compares on instr_valid.
module tb_ifetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic [31:0] instr;
  logic [5:0]  op;
  logic [5:0]  functy;
  logic        instr_valid;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        pcbranch = 1'b0;
  logic        pcjmp = 1'b0;
  logic        pcreg = 1'b0;
  logic [31:0] reg_target = 32'd0;
  logic        halt_req = 1'b0;
  logic        halted;
  logic        fault;
  logic [31:0] instr_cnt;
  logic [31:0] branch_cnt;
  logic [31:0] jump_cnt;

  ifetch_unit_if imem_bus ();

  ifetch_unit #(
    .RESET_PC  (32'h0000_0000),
    .CNT_WIDTH (32)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .imem        (imem_bus),
    .instr       (instr),
    .op          (op),
    .functy      (functy),
    .instr_valid (instr_valid),
    .pc          (pc),
    .pc_plus4    (pc_plus4),
    .pcbranch    (pcbranch),
    .pcjmp       (pcjmp),
    .pcreg       (pcreg),
    .reg_target  (reg_target),
    .halt_req    (halt_req),
    .halted      (halted),
    .fault       (fault),
    .instr_cnt   (instr_cnt),
    .branch_cnt  (branch_cnt),
    .jump_cnt    (jump_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] word;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   exec_seen = 0;

  // Reference model state
  logic [31:0] m_pc;
  logic [31:0] m_icnt;
  logic [31:0] m_bcnt;
  logic [31:0] m_jcnt;
  logic        m_halted;
  logic        m_fault;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc     = 32'd0;
    m_icnt   = 32'd0;
    m_bcnt   = 32'd0;
    m_jcnt   = 32'd0;
    m_halted = 1'b0;
    m_fault  = 1'b0;
    exp_q.delete();
  endtask

  task automatic chk_state(input string tag);
    chk({tag, "_pc"}, pc, m_pc);
    chk({tag, "_instr_cnt"}, instr_cnt, m_icnt);
    chk({tag, "_branch_cnt"}, branch_cnt, m_bcnt);
    chk({tag, "_jump_cnt"}, jump_cnt, m_jcnt);
    chk({tag, "_halted"}, {31'd0, halted}, {31'd0, m_halted});
    chk({tag, "_fault"}, {31'd0, fault}, {31'd0, m_fault});
  endtask

  // Monitor: every executing instruction must match the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && instr_valid) begin
        exec_seen++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL exec_unexpected: got exec at pc %h expected none", pc);
        end else begin
          e = exp_q.pop_front();
          chk("exec_pc", pc, e.pc);
          chk("exec_instr", instr, e.word);
          chk("exec_op", {26'd0, op}, {26'd0, e.word[31:26]});
          chk("exec_functy", {26'd0, functy}, {26'd0, e.word[5:0]});
          chk("exec_pc_plus4", pc_plus4, e.pc + 32'd4);
        end
      end
    end
  end

  // One instruction: wait for the fetch, answer after `waits` cycles, then act as decoder.
  // Must be entered on a falling edge.
  task automatic run_instr(input logic [31:0] word, input int waits, input bit br,
                           input bit jmp, input bit rg, input logic [31:0] tgt,
                           input bit hlt, input bit drop_en);
    bit          seen;
    int          e0;
    int signed   off;
    logic [31:0] lo;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (imem_bus.imem_req) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("fetch_req_seen", {31'd0, seen}, 32'd1);
    if (!seen) return;
    chk("fetch_addr", imem_bus.imem_addr, m_pc);
    for (int i = 0; i < waits; i++) begin
      @(negedge clk);
      chk("wait_req", {31'd0, imem_bus.imem_req}, 32'd1);
      chk("wait_addr", imem_bus.imem_addr, m_pc);
    end
    e0 = exec_seen;
    exp_q.push_back('{pc: m_pc, word: word});
    imem_bus.imem_valid = 1'b1;
    imem_bus.imem_rdata = word;
    if (drop_en) en = 1'b0;
    @(negedge clk);
    imem_bus.imem_valid = 1'b0;
    imem_bus.imem_rdata = $urandom();
    pcbranch   = br;
    pcjmp      = jmp;
    pcreg      = rg;
    reg_target = tgt;
    halt_req   = hlt;
    @(negedge clk);
    pcbranch = 1'b0;
    pcjmp    = 1'b0;
    pcreg    = 1'b0;
    halt_req = 1'b0;
    // Reference: architectural next-PC rules
    m_icnt = m_icnt + 1;
    if (hlt) begin
      m_halted = 1'b1;
    end else if (rg && (tgt % 4 != 0)) begin
      m_halted = 1'b1;
      m_fault  = 1'b1;
    end else if (rg) begin
      m_pc   = tgt;
      m_jcnt = m_jcnt + 1;
    end else if (jmp) begin
      lo     = word & 32'h03FF_FFFF;
      m_pc   = ((m_pc + 32'd4) & 32'hF000_0000) | (lo * 4);
      m_jcnt = m_jcnt + 1;
    end else if (br) begin
      lo     = word & 32'h0000_FFFF;
      off    = (lo >= 32'h8000) ? int'(lo) - 65536 : int'(lo);
      m_pc   = m_pc + 32'd4 + 32'(off * 4);
      m_bcnt = m_bcnt + 1;
    end else begin
      m_pc = m_pc + 32'd4;
    end
    chk("exec_once", exec_seen, e0 + 1);
    chk("post_instr_valid", {31'd0, instr_valid}, 32'd0);
    chk("post_req", {31'd0, imem_bus.imem_req}, {31'd0, !m_halted && !drop_en});
    chk_state("post");
    if (drop_en) en = 1'b1;
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_req"}, {31'd0, imem_bus.imem_req}, 32'd0);
    chk({tag, "_addr"}, imem_bus.imem_addr, 32'd0);
    chk({tag, "_instr"}, instr, 32'd0);
    chk({tag, "_instr_valid"}, {31'd0, instr_valid}, 32'd0);
    chk({tag, "_halted"}, {31'd0, halted}, 32'd0);
    chk({tag, "_fault"}, {31'd0, fault}, 32'd0);
    chk({tag, "_pc"}, pc, 32'd0);
    chk({tag, "_cnts"}, instr_cnt | branch_cnt | jump_cnt, 32'd0);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    en  = 1'b0;
    rst = 1'b1;
    #1;
    chk_reset_values("rst");
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    en = 1'b1;
  endtask

  initial begin
    logic [31:0] w;
    logic [31:0] t;
    bit          seen;
    imem_bus.imem_valid = 1'b0;
    imem_bus.imem_rdata = 32'd0;
    model_reset();
    repeat (2) @(negedge clk);
    chk_reset_values("init");
    rst = 1'b0;
    en  = 1'b1;

    // Three zero-wait adds: pc 0, 4, 8
    for (int i = 0; i < 3; i++) run_instr(32'h0000_0020, 0, 0, 0, 0, 0, 0, 0);
    chk("add3_instr_cnt", instr_cnt, 32'd3);
    chk("add3_branch_cnt", branch_cnt, 32'd0);

    // beq at 0x10 with imm -4: taken -> 0x04, not taken -> 0x14
    run_instr(32'h0000_0008, 0, 0, 0, 1, 32'h10, 0, 0);
    run_instr(32'h1000_FFFC, 0, 1, 0, 0, 0, 0, 0);
    chk("beq_taken_pc", pc, 32'h0000_0004);
    run_instr(32'h0000_0008, 1, 0, 0, 1, 32'h10, 0, 0);
    run_instr(32'h1000_FFFC, 0, 0, 0, 0, 0, 0, 0);
    chk("beq_not_taken_pc", pc, 32'h0000_0014);

    // j at 0x1000_0000, then pcreg beating pcjmp
    run_instr(32'h0000_0008, 0, 0, 0, 1, 32'h1000_0000, 0, 0);
    run_instr(32'h0800_0100, 0, 0, 1, 0, 0, 0, 0);
    chk("j_pc", pc, 32'h1000_0400);
    run_instr(32'h0800_0100, 0, 0, 1, 1, 32'h40, 0, 0);
    chk("pcreg_wins_pc", pc, 32'h0000_0040);

    // Three wait cycles; en dropped mid-fetch
    run_instr(32'h0000_0020, 3, 0, 0, 0, 0, 0, 0);
    run_instr(32'h0000_0020, 2, 0, 0, 0, 0, 0, 1);

    // Randomized traffic, no halts
    for (int i = 0; i < 60; i++) begin
      w = $urandom();
      t = $urandom();
      t[1:0] = 2'b00;
      run_instr(w, $urandom_range(0, 3), 1'($urandom_range(0, 1)),
                ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0), t, 0,
                ($urandom_range(0, 5) == 0));
    end
    chk_state("random_end");

    // Misaligned jr -> fault halt; later responses ignored
    run_instr(32'h0000_0008, 0, 0, 0, 1, 32'h42, 0, 0);
    chk("jr_mis_halted", {31'd0, halted}, 32'd1);
    chk("jr_mis_fault", {31'd0, fault}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      imem_bus.imem_valid = 1'b1;
      imem_bus.imem_rdata = $urandom();
      @(negedge clk);
      imem_bus.imem_valid = 1'b0;
      chk("halt_req_low", {31'd0, imem_bus.imem_req}, 32'd0);
    end
    chk_state("halt_hold");

    // halt_req beats pcjmp at 0x20
    apply_reset();
    run_instr(32'h0000_0008, 0, 0, 0, 1, 32'h20, 0, 0);
    run_instr(32'h0000_000C, 1, 0, 1, 0, 0, 1, 0);
    chk("syscall_pc", pc, 32'h0000_0020);
    chk("syscall_instr_cnt", instr_cnt, 32'd2);
    chk("syscall_jump_cnt", jump_cnt, 32'd1);
    chk("syscall_fault", {31'd0, fault}, 32'd0);

    // Reset asserted in the middle of a fetch
    apply_reset();
    run_instr(32'h0000_0020, 0, 0, 0, 0, 0, 0, 0);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (imem_bus.imem_req) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("midfetch_req_seen", {31'd0, seen}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk_reset_values("midfetch");
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("final_queue_empty", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Hard time limit so the run always ends
  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish before limit");
    $fatal(1, "timeout");
  end

endmodule
